// File: rtl/wb_to_apb_master.sv
// ---------------------------------------------------------------------------
// wb_to_apb_master
//
// Bridges a pipelined Wishbone slave port onto an APB4 master port. One
// Wishbone request is carried at a time; each accepted request becomes exactly
// one APB SETUP + ACCESS transfer, and the APB completion returns as a single
// registered Wishbone ack (OK) or err (PSLVERR) pulse.
//
// Ports:
//   i_clk, i_reset       shared clock (also PCLK), async active-high reset
//   i_wb_cyc/stb/we      Wishbone cycle, strobe, write enable
//   i_wb_addr            Wishbone word address (AW bits)
//   i_wb_data, i_wb_sel  Wishbone write data and byte selects
//   o_wb_stall           high while a transfer is in flight
//   o_wb_ack, o_wb_err   one-cycle completion pulses (never both high)
//   o_wb_data            read data, updated on read completion, else held
//   o_apb_*              APB4 master request signals (byte address PADDR)
//   i_apb_pready/prdata/pslverr   APB slave response
//
// DW must be 8, 16, 32 or 64; LGBYTES is derived and not overridden.
// ---------------------------------------------------------------------------
module wb_to_apb_master #(
  parameter int AW      = 28,
  parameter int DW      = 32,
  parameter int LGBYTES = $clog2(DW/8)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [AW-1:0]         i_wb_addr,
  input  logic [DW-1:0]         i_wb_data,
  input  logic [DW/8-1:0]       i_wb_sel,
  output logic                  o_wb_stall,
  output logic                  o_wb_ack,
  output logic [DW-1:0]         o_wb_data,
  output logic                  o_wb_err,
  output logic [AW+LGBYTES-1:0] o_apb_paddr,
  output logic                  o_apb_psel,
  output logic                  o_apb_penable,
  output logic                  o_apb_pwrite,
  output logic [DW-1:0]         o_apb_pwdata,
  output logic [DW/8-1:0]       o_apb_pstrb,
  input  logic                  i_apb_pready,
  input  logic [DW-1:0]         i_apb_prdata,
  input  logic                  i_apb_pslverr
);

  localparam int PAW = AW + LGBYTES;
  localparam int SW  = DW / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic           abort_r;
  logic           abort_next_s;
  logic           psel_r;
  logic           psel_next_s;
  logic           penable_r;
  logic           penable_next_s;
  logic           ack_r;
  logic           ack_next_s;
  logic           err_r;
  logic           err_next_s;
  logic           accept_s;
  logic           done_s;
  logic [PAW-1:0] paddr_s;

  // Stall is decoded straight from the registered state.
  assign o_wb_stall = (state_r != IDLE);
  assign accept_s   = i_wb_cyc && i_wb_stb && (state_r == IDLE);
  assign done_s     = (state_r == ACCESS) && i_apb_pready;
  assign paddr_s    = PAW'(i_wb_addr) << LGBYTES;

  assign o_apb_psel    = psel_r;
  assign o_apb_penable = penable_r;
  // A response pulse is never presented to a master that has left the cycle.
  assign o_wb_ack      = ack_r && i_wb_cyc;
  assign o_wb_err      = err_r && i_wb_cyc;

  // Next-state, APB control and response decode.
  always_comb begin
    next_state_s   = state_r;
    abort_next_s   = abort_r;
    psel_next_s    = 1'b0;
    penable_next_s = 1'b0;
    ack_next_s     = 1'b0;
    err_next_s     = 1'b0;
    case (state_r)
      IDLE: begin
        abort_next_s = 1'b0;
        if (accept_s) begin
          next_state_s = SETUP;
          psel_next_s  = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP: begin
        next_state_s   = ACCESS;
        psel_next_s    = 1'b1;
        penable_next_s = 1'b1;
        abort_next_s   = abort_r || !i_wb_cyc;
      end
      ACCESS: begin
        if (i_apb_pready) begin
          next_state_s = IDLE;
          abort_next_s = 1'b0;
          // A cyc drop in the completing cycle still counts as an abort.
          if (!abort_r && i_wb_cyc) begin
            ack_next_s = !i_apb_pslverr;
            err_next_s = i_apb_pslverr;
          end else begin
            ack_next_s = 1'b0;
            err_next_s = 1'b0;
          end
        end else begin
          psel_next_s    = 1'b1;
          penable_next_s = 1'b1;
          abort_next_s   = abort_r || !i_wb_cyc;
        end
      end
      default: begin
        next_state_s = IDLE;
        abort_next_s = 1'b0;
      end
    endcase
  end

  // State, abort flag, APB control and response pulse registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= IDLE;
      abort_r   <= 1'b0;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      abort_r   <= abort_next_s;
      psel_r    <= psel_next_s;
      penable_r <= penable_next_s;
      ack_r     <= ack_next_s;
      err_r     <= err_next_s;
    end
  end

  // Request capture on accept (held through ACCESS) and read-data capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_apb_paddr  <= {PAW{1'b0}};
      o_apb_pwrite <= 1'b0;
      o_apb_pwdata <= {DW{1'b0}};
      o_apb_pstrb  <= {SW{1'b0}};
      o_wb_data    <= {DW{1'b0}};
    end else begin
      if (accept_s) begin
        o_apb_paddr  <= paddr_s;
        o_apb_pwrite <= i_wb_we;
        o_apb_pwdata <= i_wb_data;
        // Reads carry no byte strobes.
        o_apb_pstrb  <= i_wb_we ? i_wb_sel : {SW{1'b0}};
      end
      if (done_s && !o_apb_pwrite) begin
        o_wb_data <= i_apb_prdata;
      end
    end
  end

endmodule

// File: tb/tb_wb_to_apb_master.sv
// ---------------------------------------------------------------------------
// tb_wb_to_apb_master
//
// Scoreboard bench for wb_to_apb_master. Each issued request pushes the APB
// transfer it must produce (plus the slave's planned response) into apb_plan,
// and the Wishbone response it must produce into wb_exp. An APB slave model
// pops apb_plan at every SETUP and answers; a Wishbone monitor pops wb_exp at
// every ack/err. Directed checks cover reset, latency, back-to-back and abort.
// ---------------------------------------------------------------------------
module tb_wb_to_apb_master;

  localparam int AW  = 28;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int PAW = AW + 2;

  typedef struct {
    logic [PAW-1:0] paddr;
    logic           pwrite;
    logic [DW-1:0]  pwdata;
    logic [SW-1:0]  pstrb;
    int             waits;
    logic           err;
    logic [DW-1:0]  rdata;
  } plan_t;

  typedef struct {
    logic          err;
    logic          is_read;
    logic [DW-1:0] data;
  } resp_t;

  logic           clk;
  logic           rst;
  logic           cyc, stb, we;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  wdata;
  logic [SW-1:0]  sel;
  logic           o_wb_stall, o_wb_ack, o_wb_err;
  logic [DW-1:0]  o_wb_data;
  logic [PAW-1:0] o_apb_paddr;
  logic           o_apb_psel, o_apb_penable, o_apb_pwrite;
  logic [DW-1:0]  o_apb_pwdata;
  logic [SW-1:0]  o_apb_pstrb;
  logic           pready, pslverr;
  logic [DW-1:0]  prdata;

  plan_t apb_plan[$];
  resp_t wb_exp[$];
  int    total = 0;
  int    bad   = 0;

  wb_to_apb_master #(.AW(AW), .DW(DW)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_wb_cyc      (cyc),
    .i_wb_stb      (stb),
    .i_wb_we       (we),
    .i_wb_addr     (addr),
    .i_wb_data     (wdata),
    .i_wb_sel      (sel),
    .o_wb_stall    (o_wb_stall),
    .o_wb_ack      (o_wb_ack),
    .o_wb_data     (o_wb_data),
    .o_wb_err      (o_wb_err),
    .o_apb_paddr   (o_apb_paddr),
    .o_apb_psel    (o_apb_psel),
    .o_apb_penable (o_apb_penable),
    .o_apb_pwrite  (o_apb_pwrite),
    .o_apb_pwdata  (o_apb_pwdata),
    .o_apb_pstrb   (o_apb_pstrb),
    .i_apb_pready  (pready),
    .i_apb_prdata  (prdata),
    .i_apb_pslverr (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected / not seen", name);
  endtask

  function automatic plan_t mk_plan(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [SW-1:0] s, input int wt, input logic e,
                                    input logic [DW-1:0] rd);
    plan_t p;
    p.paddr  = PAW'(a) * 4;
    p.pwrite = w;
    p.pwdata = d;
    p.pstrb  = w ? s : 4'h0;
    p.waits  = wt;
    p.err    = e;
    p.rdata  = rd;
    return p;
  endfunction

  function automatic resp_t mk_resp(input logic w, input logic e, input logic [DW-1:0] rd);
    resp_t r;
    r.err     = e;
    r.is_read = !w;
    r.data    = rd;
    return r;
  endfunction

  // APB slave model: checks each transfer against the plan and answers it.
  initial begin
    plan_t cur;
    bit    active;
    int    w;
    active  = 1'b0;
    w       = 0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active  = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
      end else if (o_apb_psel && !o_apb_penable) begin
        if (active) fail("apb_setup_while_active");
        if (apb_plan.size() == 0) begin
          fail("apb_unexpected_setup");
          active = 1'b0;
        end else begin
          cur    = apb_plan.pop_front();
          active = 1'b1;
          w      = cur.waits;
          check("apb_setup_req", {o_apb_paddr, o_apb_pwrite, o_apb_pwdata, o_apb_pstrb},
                {cur.paddr, cur.pwrite, cur.pwdata, cur.pstrb});
        end
        // Response lines are don't-care in SETUP; drive noise.
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end else if (o_apb_psel && o_apb_penable) begin
        if (!active) begin
          fail("apb_access_without_setup");
          pready = 1'b1;
        end else begin
          check("apb_access_stable", {o_apb_paddr, o_apb_pwrite, o_apb_pwdata, o_apb_pstrb},
                {cur.paddr, cur.pwrite, cur.pwdata, cur.pstrb});
          if (w == 0) begin
            pready  = 1'b1;
            pslverr = cur.err;
            prdata  = cur.rdata;
            active  = 1'b0;
          end else begin
            w--;
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
          end
        end
      end else begin
        check("apb_idle_penable", o_apb_penable, 1'b0);
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
    end
  end

  // Wishbone response monitor: every ack/err must match the oldest expectation.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("wb_ack_err_exclusive", o_wb_ack & o_wb_err, 1'b0);
        if (o_wb_ack || o_wb_err) begin
          if (wb_exp.size() == 0) begin
            fail("wb_unexpected_response");
          end else begin
            r = wb_exp.pop_front();
            check("wb_resp_kind", {o_wb_ack, o_wb_err}, {!r.err, r.err});
            if (r.is_read) check("wb_read_data", o_wb_data, r.data);
          end
        end
      end
    end
  end

  task automatic drive_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
    cyc   = 1'b1;
    stb   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    sel   = s;
  endtask

  // One complete request through the bridge, optionally abandoned in ACCESS.
  task automatic do_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int wt, input logic e,
                        input logic [DW-1:0] rd, input logic abort);
    int n;
    bit done;
    apb_plan.push_back(mk_plan(w, a, d, s, wt, e, rd));
    if (!abort) wb_exp.push_back(mk_resp(w, e, rd));
    @(posedge clk); #1;
    drive_req(w, a, d, s);
    n = 0; done = 1'b0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (!o_wb_stall) done = 1'b1;
      n++;
    end
    if (!done) fail("accept_timeout");
    @(posedge clk); #1;
    stb = 1'b0;
    n = 0; done = 1'b0;
    if (abort) begin
      @(posedge clk); #1;
      cyc = 1'b0;
      while (!done && n < 50) begin
        @(negedge clk);
        if (!o_wb_stall) done = 1'b1;
        n++;
      end
      if (!done) fail("abort_drain_timeout");
    end else begin
      while (!done && n < 50) begin
        @(negedge clk);
        if (o_wb_ack || o_wb_err) done = 1'b1;
        n++;
      end
      if (!done) fail("response_timeout");
      @(posedge clk); #1;
      cyc = 1'b0;
    end
  endtask

  // Zero-wait write with cycle-exact latency and bus sequencing checks.
  task automatic latency_test();
    apb_plan.push_back(mk_plan(1'b1, 28'h0000010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0));
    wb_exp.push_back(mk_resp(1'b1, 1'b0, 32'h0));
    @(posedge clk); #1;
    drive_req(1'b1, 28'h0000010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("lat_n_stall_psel", {o_wb_stall, o_apb_psel}, 2'b00);
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    check("lat_n1_setup", {o_wb_stall, o_apb_psel, o_apb_penable}, 3'b110);
    check("lat_n1_paddr_pstrb", {o_apb_paddr, o_apb_pstrb}, {30'h0000040, 4'hF});
    @(negedge clk);
    check("lat_n2_access", {o_wb_stall, o_apb_psel, o_apb_penable}, 3'b111);
    @(negedge clk);
    check("lat_n3_ack", {o_wb_ack, o_wb_err, o_wb_stall, o_apb_psel}, 4'b1000);
    @(posedge clk); #1;
    cyc = 1'b0;
  endtask

  // Two requests with stb held high: one idle PSEL gap, two responses.
  task automatic b2b_test();
    int  n;
    bit  done;
    apb_plan.push_back(mk_plan(1'b1, 28'h0000100, 32'hA5A5_0001, 4'h3, 0, 1'b0, 32'h0));
    apb_plan.push_back(mk_plan(1'b0, 28'h0000101, 32'h0, 4'hF, 0, 1'b0, 32'hCAFE_F00D));
    wb_exp.push_back(mk_resp(1'b1, 1'b0, 32'h0));
    wb_exp.push_back(mk_resp(1'b0, 1'b0, 32'hCAFE_F00D));
    @(posedge clk); #1;
    drive_req(1'b1, 28'h0000100, 32'hA5A5_0001, 4'h3);
    @(posedge clk); #1;
    drive_req(1'b0, 28'h0000101, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("b2b_first_ack_gap", {o_wb_ack, o_apb_psel, o_wb_stall}, 3'b100);
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    check("b2b_second_setup", {o_apb_psel, o_apb_penable}, 2'b10);
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (o_wb_ack || o_wb_err) done = 1'b1;
      n++;
    end
    if (!done) fail("b2b_second_timeout");
    @(posedge clk); #1;
    cyc = 1'b0;
  endtask

  // Asynchronous reset in the middle of an ACCESS wait state.
  task automatic reset_mid_test();
    apb_plan.push_back(mk_plan(1'b0, 28'h0ABCDEF, 32'h0, 4'hF, 6, 1'b0, 32'h11223344));
    @(posedge clk); #1;
    drive_req(1'b0, 28'h0ABCDEF, 32'h0, 4'hF);
    @(posedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    check("rst_pre_in_access", {o_apb_psel, o_apb_penable}, 2'b11);
    rst = 1'b1;
    #1;
    check("rst_async_outputs", {o_apb_psel, o_apb_penable, o_wb_ack, o_wb_err, o_wb_stall}, 5'b00000);
    apb_plan.delete();
    wb_exp.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    // cyc stays high so a stale ack could not be masked.
    repeat (6) @(posedge clk);
    #1;
    cyc = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    cyc   = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    sel   = '0;
    #1 rst = 1'b1;
    #2;
    check("reset_ctrl", {o_apb_psel, o_apb_penable, o_wb_ack, o_wb_err, o_wb_stall}, 5'b00000);
    check("reset_data", {o_apb_paddr, o_apb_pwrite, o_apb_pwdata, o_apb_pstrb, o_wb_data}, '0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    latency_test();
    // Read with three wait states: PENABLE held for four ACCESS cycles.
    do_txn(1'b0, 28'h0000200, 32'h0, 4'hF, 3, 1'b0, 32'h12345678, 1'b0);
    // Slave error on a write.
    do_txn(1'b1, 28'h0000300, 32'h55AA55AA, 4'h5, 0, 1'b1, 32'h0, 1'b0);
    // Abort two cycles before PREADY, then a normal request must be acked.
    do_txn(1'b1, 28'h0000400, 32'h01020304, 4'hF, 2, 1'b0, 32'h0, 1'b1);
    do_txn(1'b0, 28'h0000404, 32'h0, 4'hF, 1, 1'b0, 32'h87654321, 1'b0);
    // Abort coinciding with PREADY.
    do_txn(1'b0, 28'h0000500, 32'h0, 4'hF, 0, 1'b0, 32'hFFFF0000, 1'b1);
    b2b_test();

    for (int i = 0; i < 60; i++) begin
      do_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom,
             ($urandom_range(0, 5) == 0));
    end

    reset_mid_test();
    do_txn(1'b0, 28'h0000600, 32'h0, 4'hF, 2, 1'b0, 32'h0BADF00D, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("end_apb_plan_empty", apb_plan.size(), 0);
    check("end_wb_exp_empty", wb_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
